// File: rtl/md_sched.sv
// Multiply/divide sequencer and HI/LO register pair for the EX stage.
// Launches mult/multu/div/divu, counts down the busy latency, commits HI/LO, serves mf*/mt*.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins_e,
    input  logic [31:0] ins_d,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DW    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      op_kind;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;

    // EX / D decode: R-type opcode 0, md functs live in 01_0xxx and 01_10xx
    logic e_rtype;
    logic e_start;
    logic e_mthi;
    logic e_mtlo;
    logic e_mfhi;
    logic e_mflo;
    logic d_md;
    logic unused_ins_bits;

    assign e_rtype = (ins_e[31:26] == 6'b000000);
    assign e_start = e_rtype && (ins_e[5:2] == 4'b0110);
    assign e_mfhi  = e_rtype && (ins_e[5:0] == 6'b010000);
    assign e_mthi  = e_rtype && (ins_e[5:0] == 6'b010001);
    assign e_mflo  = e_rtype && (ins_e[5:0] == 6'b010010);
    assign e_mtlo  = e_rtype && (ins_e[5:0] == 6'b010011);
    assign d_md    = (ins_d[31:26] == 6'b000000) &&
                     ((ins_d[5:2] == 4'b0110) || (ins_d[5:2] == 4'b0100));
    assign unused_ins_bits = ^{ins_e[25:6], ins_d[25:6]};

    // Result datapath from the latched operands
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          div_signed;
    logic          div_zero;
    logic [DW-1:0] dvd_mag;
    logic [DW-1:0] dvs_mag;
    logic [DW-1:0] q_mag;
    logic [DW-1:0] r_mag;
    logic [DW-1:0] quot;
    logic [DW-1:0] rem;

    assign prod_s = {{DW{op_a[DW-1]}}, op_a} * {{DW{op_b[DW-1]}}, op_b};
    assign prod_u = {DW'(0), op_a} * {DW'(0), op_b};

    assign div_signed = (op_kind == 2'b10);
    assign div_zero   = (op_b == DW'(0));

    // Signed divide via magnitudes avoids the INT_MIN / -1 corner of native signed division
    assign dvd_mag = (div_signed && op_a[DW-1]) ? DW'(-op_a) : op_a;
    assign dvs_mag = div_zero ? DW'(1)
                   : ((div_signed && op_b[DW-1]) ? DW'(-op_b) : op_b);
    assign q_mag   = dvd_mag / dvs_mag;
    assign r_mag   = dvd_mag % dvs_mag;
    assign quot    = (div_signed && (op_a[DW-1] ^ op_b[DW-1])) ? DW'(-q_mag) : q_mag;
    assign rem     = (div_signed && op_a[DW-1]) ? DW'(-r_mag) : r_mag;

    // Sequencer: IDLE launches or services mt*, BUSY counts down and commits on the last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_kind <= '0;
            op_a    <= '0;
            op_b    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (e_start) begin
                        op_a    <= rs_val;
                        op_b    <= rt_val;
                        op_kind <= ins_e[1:0];
                        cnt     <= ins_e[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state   <= BUSY;
                    end else if (e_mthi) begin
                        hi <= rs_val;
                    end else if (e_mtlo) begin
                        lo <= rs_val;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        case (op_kind)
                            2'b00: {hi, lo} <= prod_s;
                            2'b01: {hi, lo} <= prod_u;
                            default: begin
                                if (!div_zero) begin
                                    hi <= rem;
                                    lo <= quot;
                                end
                            end
                        endcase
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign stall_req = d_md && (busy || e_start);
    assign md_rdata  = e_mfhi ? hi : (e_mflo ? lo : '0);

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_md_sched;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MULT  = 32'h0000_0018;
    localparam logic [31:0] MULTU = 32'h0000_0019;
    localparam logic [31:0] DIV   = 32'h0000_001A;
    localparam logic [31:0] DIVU  = 32'h0000_001B;
    localparam logic [31:0] MFHI  = 32'h0000_0010;
    localparam logic [31:0] MTHI  = 32'h0000_0011;
    localparam logic [31:0] MFLO  = 32'h0000_0012;
    localparam logic [31:0] MTLO  = 32'h0000_0013;
    localparam logic [31:0] ADDU  = 32'h0000_0021;
    localparam logic [31:0] IMM18 = 32'h2000_0018;
    localparam logic [31:0] IMM10 = 32'h2000_0010;

    localparam int F_BUSY  = 0;
    localparam int F_STALL = 1;
    localparam int F_RDATA = 2;
    localparam int F_HI    = 3;
    localparam int F_LO    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ins_e = '0;
    logic [31:0] ins_d = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_e     (ins_e),
        .ins_d     (ins_d),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .md_rdata  (md_rdata),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        int          field;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic [31:0] ie, input logic [31:0] id,
                        input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk);
        #1;
        ins_e  = ie;
        ins_d  = id;
        rs_val = rs;
        rt_val = rt;
    endtask

    task automatic exp_push(input int f, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc   = cyc;
        e.field = f;
        e.val   = v;
        e.name  = n;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int f);
        case (f)
            F_BUSY:  return 32'(busy);
            F_STALL: return 32'(stall_req);
            F_RDATA: return md_rdata;
            F_HI:    return hi;
            default: return lo;
        endcase
    endfunction

    // Monitor: compare every expectation that belongs to the current cycle
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = actual(e.field);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d actual=%08h expected=%08h", e.name, cyc, a, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "rst_busy");
        exp_push(F_HI, 32'h0, "rst_hi");
        exp_push(F_LO, 32'h0, "rst_lo");
        exp_push(F_STALL, 32'h0, "rst_stall");
        #3 rst_n = 1'b1;

        // Reset in the middle of a divide
        step(MTHI, NOP, 32'h55, 32'h0);
        step(DIV, NOP, 32'h7, 32'h2);
        exp_push(F_HI, 32'h55, "mthi_pre_div");
        exp_push(F_BUSY, 32'h0, "div_start_busy");
        step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h1, "div_busy_pre_rst");
        step(NOP, NOP, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        exp_push(F_BUSY, 32'h0, "midop_rst_busy");
        exp_push(F_HI, 32'h0, "midop_rst_hi");
        exp_push(F_LO, 32'h0, "midop_rst_lo");
        #4 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "no_commit_busy");
        exp_push(F_HI, 32'h0, "no_commit_hi");
        exp_push(F_LO, 32'h0, "no_commit_lo");

        // mult -2 * 3 with mfhi waiting in D; illegal ops while busy are ignored
        step(MULT, MFHI, 32'hFFFF_FFFE, 32'h3);
        exp_push(F_STALL, 32'h1, "mult_start_stall");
        exp_push(F_BUSY, 32'h0, "mult_start_busy");
        for (int i = 1; i <= 5; i++) begin
            step((i == 1) ? MTLO : (i == 2) ? MULTU : (i == 3) ? MFLO : NOP,
                 MFHI, 32'h0000_DEAD, 32'h7);
            exp_push(F_BUSY, 32'h1, "mult_busy");
            exp_push(F_STALL, 32'h1, "mult_busy_stall");
            if (i == 2) exp_push(F_LO, 32'h0, "mtlo_while_busy");
            if (i == 3) exp_push(F_RDATA, 32'h0, "mflo_while_busy");
        end
        step(MFLO, MFHI, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "mult_done_busy");
        exp_push(F_STALL, 32'h0, "mult_done_stall");
        exp_push(F_HI, 32'hFFFF_FFFF, "mult_hi");
        exp_push(F_LO, 32'hFFFF_FFFA, "mult_lo");
        exp_push(F_RDATA, 32'hFFFF_FFFA, "mult_mflo");

        // multu with a non-md instruction in D never stalls
        step(MULTU, ADDU, 32'hFFFF_FFFF, 32'h2);
        exp_push(F_STALL, 32'h0, "multu_start_stall");
        for (int i = 0; i < 5; i++) begin
            step(NOP, ADDU, 32'h0, 32'h0);
            exp_push(F_BUSY, 32'h1, "multu_busy");
            exp_push(F_STALL, 32'h0, "multu_addu_stall");
        end
        step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "multu_done_busy");
        exp_push(F_HI, 32'h0000_0001, "multu_hi");
        exp_push(F_LO, 32'hFFFF_FFFE, "multu_lo");

        // Non-R-type encodings with md funct bits are no-ops
        step(IMM18, IMM10, 32'h5, 32'h5);
        exp_push(F_STALL, 32'h0, "nonr_stall");
        step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "nonr_busy");
        exp_push(F_HI, 32'h0000_0001, "nonr_hi");

        // div -7 / 2
        step(DIV, NOP, 32'hFFFF_FFF9, 32'h2);
        exp_push(F_BUSY, 32'h0, "div_start_busy2");
        for (int i = 1; i <= 10; i++) begin
            step(NOP, NOP, 32'h0, 32'h0);
            exp_push(F_BUSY, 32'h1, "div_busy");
            if (i == 10) exp_push(F_HI, 32'h0000_0001, "div_last_busy_hi");
        end
        step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "div_done_busy");
        exp_push(F_LO, 32'hFFFF_FFFD, "div_lo");
        exp_push(F_HI, 32'hFFFF_FFFF, "div_hi");

        // div 7 / -2
        step(DIV, NOP, 32'h7, 32'hFFFF_FFFE);
        for (int i = 0; i < 11; i++) step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_LO, 32'hFFFF_FFFD, "div_negdvs_lo");
        exp_push(F_HI, 32'h0000_0001, "div_negdvs_hi");

        // divu by zero leaves HI/LO alone
        step(MTHI, NOP, 32'h11, 32'h0);
        step(MTLO, NOP, 32'h22, 32'h0);
        step(DIVU, NOP, 32'h5, 32'h0);
        exp_push(F_HI, 32'h11, "divz_pre_hi");
        exp_push(F_LO, 32'h22, "divz_pre_lo");
        for (int i = 0; i < 10; i++) begin
            step(NOP, NOP, 32'h0, 32'h0);
            exp_push(F_BUSY, 32'h1, "divz_busy");
        end
        step(NOP, NOP, 32'h0, 32'h0);
        exp_push(F_BUSY, 32'h0, "divz_done_busy");
        exp_push(F_HI, 32'h11, "divz_hi");
        exp_push(F_LO, 32'h22, "divz_lo");

        // mthi then mfhi
        step(MTHI, NOP, 32'hABCD_1234, 32'h0);
        step(MFHI, NOP, 32'h0, 32'h0);
        exp_push(F_RDATA, 32'hABCD_1234, "mfhi_after_mthi");
        step(MFLO, NOP, 32'h0, 32'h0);
        exp_push(F_RDATA, 32'h22, "mflo_read");
        step(ADDU, NOP, 32'h0, 32'h0);
        exp_push(F_RDATA, 32'h0, "rdata_other");

        step(NOP, NOP, 32'h0, 32'h0);
        step(NOP, NOP, 32'h0, 32'h0);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
